// File: rtl/onfi_sdr_cycle_gen.sv
// onfi_sdr_cycle_gen: host-side ONFI SDR bus cycle generator.
// Turns single byte operations (CMD/ADDR/WRITE/READ/WAIT_RB) into timed
// CE/CLE/ALE/WE/RE/IO pin waveforms and watches R/B# with a timeout.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   op_valid/op_ready/op_type/op_data/op_last   operation handshake
//   wp_n_in                          write-protect request (to WP_x_n)
//   rd_valid/rd_data                 captured read byte (one-cycle pulse)
//   err                              one-cycle pulse: R/B timeout / illegal op
//   CE_x_n/CLE_x/ALE_x/WE_x_n/RE_x_n/WP_x_n   NAND control pins
//   R_B_x_n                          ready/busy from device (async)
//   io_o/io_oe/io_i                  IO[7:0] drive value, enable, sample
`timescale 1ns/1ps
module onfi_sdr_cycle_gen #(
   parameter int unsigned T_SETUP    = 2,
   parameter int unsigned T_WP       = 3,
   parameter int unsigned T_WH       = 2,
   parameter int unsigned T_RP       = 3,
   parameter int unsigned T_REH      = 2,
   parameter int unsigned T_WB       = 5,
   parameter int unsigned RB_TIMEOUT = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       op_valid,
   output logic       op_ready,
   input  logic [2:0] op_type,
   input  logic [7:0] op_data,
   input  logic       op_last,
   input  logic       wp_n_in,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       err,
   output logic       CE_x_n,
   output logic       CLE_x,
   output logic       ALE_x,
   output logic       WE_x_n,
   output logic       RE_x_n,
   output logic       WP_x_n,
   input  logic       R_B_x_n,
   output logic [7:0] io_o,
   output logic       io_oe,
   input  logic [7:0] io_i
);

   localparam int unsigned TW = (RB_TIMEOUT < 2) ? 1 : $clog2(RB_TIMEOUT + 1);

   // Counter load values: a state lasting N cycles loads N-1 and exits at 0.
   localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
   localparam logic [7:0] LD_WP    = 8'(T_WP - 1);
   localparam logic [7:0] LD_WH    = 8'(T_WH - 1);
   localparam logic [7:0] LD_RP    = 8'(T_RP - 1);
   localparam logic [7:0] LD_REH   = 8'(T_REH - 1);
   localparam logic [7:0] LD_WB    = 8'(T_WB - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(RB_TIMEOUT - 1);

   localparam logic [2:0] OP_CMD   = 3'd0;
   localparam logic [2:0] OP_ADDR  = 3'd1;
   localparam logic [2:0] OP_WRITE = 3'd2;
   localparam logic [2:0] OP_READ  = 3'd3;
   localparam logic [2:0] OP_WAIT  = 3'd4;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETUP   = 3'd1;
   localparam logic [2:0] S_STB_LO  = 3'd2;
   localparam logic [2:0] S_STB_HI  = 3'd3;
   localparam logic [2:0] S_WB_WAIT = 3'd4;
   localparam logic [2:0] S_RB_WAIT = 3'd5;

   logic [2:0]    state, state_nxt;
   logic [7:0]    cnt, cnt_nxt;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic          rd_op, rd_op_nxt;
   logic          last_op, last_nxt;
   logic          ce_nxt, cle_nxt, ale_nxt, we_nxt, re_nxt;
   logic [7:0]    io_o_nxt, rd_data_nxt;
   logic          io_oe_nxt, rd_valid_nxt, err_nxt;
   logic          rb_s1, rb_s2;

   // R/B# is asynchronous to clk: two-flop synchronizer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rb_s1 <= 1'b0;
         rb_s2 <= 1'b0;
      end else begin
         rb_s1 <= R_B_x_n;
         rb_s2 <= rb_s1;
      end
   end

   // Write protect follows its request with one cycle of latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) WP_x_n <= 1'b0;
      else        WP_x_n <= wp_n_in;
   end

   // State register plus registered pin/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= 8'd0;
         tcnt     <= '0;
         rd_op    <= 1'b0;
         last_op  <= 1'b0;
         op_ready <= 1'b1;
         CE_x_n   <= 1'b1;
         CLE_x    <= 1'b0;
         ALE_x    <= 1'b0;
         WE_x_n   <= 1'b1;
         RE_x_n   <= 1'b1;
         io_o     <= 8'd0;
         io_oe    <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= 8'd0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         tcnt     <= tcnt_nxt;
         rd_op    <= rd_op_nxt;
         last_op  <= last_nxt;
         op_ready <= (state_nxt == S_IDLE);
         CE_x_n   <= ce_nxt;
         CLE_x    <= cle_nxt;
         ALE_x    <= ale_nxt;
         WE_x_n   <= we_nxt;
         RE_x_n   <= re_nxt;
         io_o     <= io_o_nxt;
         io_oe    <= io_oe_nxt;
         rd_valid <= rd_valid_nxt;
         rd_data  <= rd_data_nxt;
         err      <= err_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      tcnt_nxt     = tcnt;
      rd_op_nxt    = rd_op;
      last_nxt     = last_op;
      ce_nxt       = CE_x_n;
      cle_nxt      = CLE_x;
      ale_nxt      = ALE_x;
      we_nxt       = 1'b1;
      re_nxt       = 1'b1;
      io_o_nxt     = io_o;
      io_oe_nxt    = io_oe;
      rd_valid_nxt = 1'b0;
      rd_data_nxt  = rd_data;
      err_nxt      = 1'b0;

      case (state)
         S_IDLE: begin
            if (op_valid) begin
               last_nxt  = op_last;
               rd_op_nxt = (op_type == OP_READ);
               case (op_type)
                  OP_CMD, OP_ADDR, OP_WRITE: begin
                     ce_nxt    = 1'b0;
                     cle_nxt   = (op_type == OP_CMD);
                     ale_nxt   = (op_type == OP_ADDR);
                     io_o_nxt  = op_data;
                     io_oe_nxt = 1'b1;
                     state_nxt = S_SETUP;
                     cnt_nxt   = LD_SETUP;
                  end
                  OP_READ: begin
                     ce_nxt    = 1'b0;
                     io_oe_nxt = 1'b0;
                     state_nxt = S_SETUP;
                     cnt_nxt   = LD_SETUP;
                  end
                  OP_WAIT: begin
                     state_nxt = S_WB_WAIT;
                     cnt_nxt   = LD_WB;
                  end
                  default: begin
                     // Illegal op: one busy cycle with err, pins untouched.
                     err_nxt   = 1'b1;
                     last_nxt  = 1'b0;
                     state_nxt = S_STB_HI;
                     cnt_nxt   = 8'd0;
                  end
               endcase
            end
         end
         S_SETUP: begin
            if (cnt == 8'd0) begin
               state_nxt = S_STB_LO;
               cnt_nxt   = rd_op ? LD_RP : LD_WP;
               re_nxt    = !rd_op;
               we_nxt    = rd_op;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         S_STB_LO: begin
            if (cnt == 8'd0) begin
               state_nxt = S_STB_HI;
               cnt_nxt   = rd_op ? LD_REH : LD_WH;
               if (rd_op) begin
                  rd_valid_nxt = 1'b1;
                  rd_data_nxt  = io_i;
               end
            end else begin
               cnt_nxt = cnt - 8'd1;
               re_nxt  = !rd_op;
               we_nxt  = rd_op;
            end
         end
         S_STB_HI: begin
            if (cnt == 8'd0) begin
               state_nxt = S_IDLE;
               cle_nxt   = 1'b0;
               ale_nxt   = 1'b0;
               io_o_nxt  = 8'd0;
               io_oe_nxt = 1'b0;
               if (last_op) ce_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         S_WB_WAIT: begin
            if (cnt == 8'd0) begin
               state_nxt = S_RB_WAIT;
               tcnt_nxt  = '0;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         S_RB_WAIT: begin
            if (rb_s2) begin
               state_nxt = S_IDLE;
               if (last_op) ce_nxt = 1'b1;
            end else if (tcnt == TO_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
               if (last_op) ce_nxt = 1'b1;
            end else begin
               tcnt_nxt = tcnt + TW'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
